// File: rtl/io_input_conditioner.sv
// Input conditioning for slide switches and pushbuttons: two-flop synchronizers, per-bit
// debounce counters, and registered press/change pulses aligned with the debounced bus.
module io_input_conditioner #(
    parameter int NUM_SW          = 10,
    parameter int NUM_KEY         = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_ni,
    input  logic [NUM_SW-1:0]          sw_raw_i,
    input  logic [NUM_KEY-1:0]         key_raw_i,
    output logic [NUM_SW+NUM_KEY-1:0]  io_input_bus_o,
    output logic [NUM_KEY-1:0]         key_press_o,
    output logic                       change_o
);

    localparam int W     = NUM_SW + NUM_KEY;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]       raw;
    logic [W-1:0]       sync_q1;
    logic [W-1:0]       sync_q2;
    logic [W-1:0]       stable_q;
    logic [W-1:0]       stable_d;
    logic [CNT_W-1:0]   cnt_q [W];
    logic [CNT_W-1:0]   cnt_d [W];
    logic [NUM_KEY-1:0] key_press_q;
    logic               change_q;

    // Keys are inverted up front so every internal bit uses 1 = active.
    assign raw = {~key_raw_i, sw_raw_i};

    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        stable_d = stable_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = '0;
            if (sync_q2[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync_q2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Pulses are registered from stable_d so they coincide with the bus update.
    always_ff @(posedge clock_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset_ni) begin
            sync_q1     <= '0;
            sync_q2     <= '0;
            stable_q    <= '0;
            key_press_q <= '0;
            change_q    <= 1'b0;
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
            // to guarantee partial counts are discarded.
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q1     <= raw;
            sync_q2     <= sync_q1;
            stable_q    <= stable_d;
            key_press_q <= stable_d[W-1:NUM_SW] & ~stable_q[W-1:NUM_SW];
            change_q    <= |(stable_d ^ stable_q);
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign io_input_bus_o = stable_q;
    assign key_press_o    = key_press_q;
    assign change_o       = change_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench: expected bus/pulse events are queued when stimulus is driven and
// compared every cycle against the DUT; a second instance covers DEBOUNCE_CYCLES = 1.
module tb_io_input_conditioner;

    logic        clock_i;
    logic        reset_ni;
    logic [9:0]  sw_raw;
    logic [3:0]  key_raw;
    logic [13:0] bus;
    logic [3:0]  kp;
    logic        chg;

    logic [9:0]  sw1_raw;
    logic [13:0] bus1;
    logic [3:0]  kp1;
    logic        chg1;

    typedef struct {
        int          cyc;
        logic [13:0] bus;
        logic [3:0]  kp;
        logic        chg;
    } ev_t;

    ev_t         sb[$];
    logic [13:0] model_bus;
    logic [13:0] exp_bus;
    logic [3:0]  exp_kp;
    logic        exp_chg;
    int          cyc;
    int          errors;
    int          checks;
    bit          mon_en;

    io_input_conditioner #(.NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(4)) u_dut (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .sw_raw_i       (sw_raw),
        .key_raw_i      (key_raw),
        .io_input_bus_o (bus),
        .key_press_o    (kp),
        .change_o       (chg)
    );

    io_input_conditioner #(.NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(1)) u_dut_fast (
        .clock_i        (clock_i),
        .reset_ni       (reset_ni),
        .sw_raw_i       (sw1_raw),
        .key_raw_i      (4'hF),
        .io_input_bus_o (bus1),
        .key_press_o    (kp1),
        .change_o       (chg1)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    always @(posedge clock_i) cyc <= cyc + 1;

    // Expected bus change at edge count 'at'; pulses derive from the previous expected bus.
    task automatic push_ev(input int at, input logic [13:0] nb);
        ev_t e;
        e.cyc = at;
        e.bus = nb;
        e.kp  = nb[13:10] & ~model_bus[13:10];
        e.chg = (nb != model_bus);
        sb.push_back(e);
        model_bus = nb;
    endtask

    // Reset sampled at edge 'at' clears everything and cancels pending changes, silently.
    task automatic push_reset(input int at);
        ev_t e;
        while (sb.size() > 0 && sb[sb.size()-1].cyc >= at) void'(sb.pop_back());
        e.cyc = at;
        e.bus = '0;
        e.kp  = '0;
        e.chg = 1'b0;
        sb.push_back(e);
        model_bus = '0;
    endtask

    // Advance n cycles; at each falling edge pop due events and compare the DUT outputs.
    task automatic tick(input int n);
        ev_t e;
        repeat (n) begin
            @(negedge clock_i);
            if (mon_en) begin
                exp_kp  = '0;
                exp_chg = 1'b0;
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    if (e.cyc < cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL stale_event cyc=%0d due=%0d", cyc, e.cyc);
                    end
                    exp_bus = e.bus;
                    exp_kp  = e.kp;
                    exp_chg = e.chg;
                end
                checks++;
                if (bus !== exp_bus) begin
                    errors++;
                    $display("FAIL bus cyc=%0d got=%h exp=%h", cyc, bus, exp_bus);
                end
                checks++;
                if (kp !== exp_kp) begin
                    errors++;
                    $display("FAIL key_press cyc=%0d got=%b exp=%b", cyc, kp, exp_kp);
                end
                checks++;
                if (chg !== exp_chg) begin
                    errors++;
                    $display("FAIL change cyc=%0d got=%b exp=%b", cyc, chg, exp_chg);
                end
            end
            @(posedge clock_i);
        end
        #1;
    endtask

    task automatic drained(input string name);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_drained pending=%0d exp=0", name, sb.size());
        end
    endtask

    task automatic test_reset;
        sw_raw  = 10'h3FF;
        key_raw = 4'hF;
        tick(10);
        reset_ni = 1'b0;
        push_ev(cyc + 6, 14'h03FF);
        tick(12);
        drained("reset");
        sw_raw = '0;
        push_ev(cyc + 6, 14'h0000);
        tick(10);
    endtask

    task automatic test_switch_patterns;
        logic [9:0] pats [3];
        pats[0] = 10'd10;
        pats[1] = 10'h2A5;
        pats[2] = 10'h000;
        foreach (pats[i]) begin
            sw_raw = pats[i];
            push_ev(cyc + 6, {4'h0, pats[i]});
            tick(10);
        end
        drained("switch_patterns");
    endtask

    task automatic test_glitch;
        key_raw[2] = 1'b0;
        tick(3);
        key_raw[2] = 1'b1;
        tick(10);
        drained("glitch");
    endtask

    task automatic test_min_pulse;
        sw_raw[5] = 1'b1;
        push_ev(cyc + 6, model_bus | 14'h0020);
        tick(4);
        sw_raw[5] = 1'b0;
        push_ev(cyc + 6, model_bus & ~14'h0020);
        tick(12);
        drained("min_pulse");
    endtask

    task automatic test_key_press;
        key_raw[0] = 1'b0;
        push_ev(cyc + 6, model_bus | 14'h0400);
        tick(20);
        key_raw[0] = 1'b1;
        push_ev(cyc + 6, model_bus & ~14'h0400);
        tick(10);
        drained("key_press");
    endtask

    task automatic test_simultaneous;
        sw_raw[0]  = 1'b1;
        key_raw[3] = 1'b0;
        push_ev(cyc + 6, model_bus | 14'h2001);
        tick(10);
        sw_raw[0]  = 1'b0;
        key_raw[3] = 1'b1;
        push_ev(cyc + 6, model_bus & ~14'h2001);
        tick(10);
        drained("simultaneous");
    endtask

    task automatic test_reset_mid;
        sw_raw[9] = 1'b1;
        push_ev(cyc + 6, model_bus | 14'h0200);
        tick(10);
        sw_raw[3] = 1'b1;
        tick(3);
        reset_ni = 1'b1;
        push_reset(cyc + 1);
        tick(2);
        reset_ni = 1'b0;
        push_ev(cyc + 6, 14'h0208);
        tick(12);
        sw_raw = '0;
        push_ev(cyc + 6, 14'h0000);
        tick(10);
        drained("reset_mid");
    endtask

    task automatic test_key_through_reset;
        reset_ni   = 1'b1;
        key_raw[1] = 1'b0;
        push_reset(cyc + 1);
        tick(4);
        reset_ni = 1'b0;
        push_ev(cyc + 6, 14'h0800);
        tick(10);
        key_raw[1] = 1'b1;
        push_ev(cyc + 6, 14'h0000);
        tick(10);
        drained("key_through_reset");
    endtask

    task automatic test_fast_debounce;
        sw1_raw = 10'h001;
        tick(2);
        checks++;
        if (bus1 !== 14'h0000) begin
            errors++;
            $display("FAIL fast_early got=%h exp=%h", bus1, 14'h0000);
        end
        tick(1);
        checks++;
        if (bus1 !== 14'h0001 || chg1 !== 1'b1) begin
            errors++;
            $display("FAIL fast_accept got=%h/%b exp=%h/%b", bus1, chg1, 14'h0001, 1'b1);
        end
        tick(1);
        checks++;
        if (chg1 !== 1'b0 || kp1 !== 4'h0) begin
            errors++;
            $display("FAIL fast_pulse_end got=%b/%b exp=%b/%b", chg1, kp1, 1'b0, 4'h0);
        end
        sw1_raw = '0;
        tick(5);
    endtask

    initial begin
        cyc       = 0;
        errors    = 0;
        checks    = 0;
        mon_en    = 1'b0;
        model_bus = '0;
        exp_bus   = '0;
        exp_kp    = '0;
        exp_chg   = 1'b0;
        reset_ni  = 1'b1;
        sw_raw    = '0;
        key_raw   = 4'hF;
        sw1_raw   = '0;
        repeat (2) @(posedge clock_i);
        #1;
        mon_en = 1'b1;
        test_reset;
        test_switch_patterns;
        test_glitch;
        test_min_pulse;
        test_key_press;
        test_simultaneous;
        test_reset_mid;
        test_key_through_reset;
        test_fast_debounce;
        drained("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
